rx_frame_ctrl: RTL and testbench
================================

RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 10, giving clock cycles per serial bit period; legal values are 4 or greater.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, giving data bits per frame; the frame is 1 start bit, DATA_BITS data bits LSB-first, and 1 stop bit.
REQ-003 clk  input  1  single system clock; all flops rising-edge.
REQ-004 n_rst  input  1  asynchronous active-low reset.
REQ-005 serial_in  input  1  raw asynchronous serial line; idle high.
REQ-006 sr_data  input  DATA_BITS+1  parallel_out of the downstream-fed shift register, instanced with NUM_BITS=DATA_BITS+1 and SHIFT_MSB=0, serial_in tied to this block's sync_serial.
REQ-007 sync_serial  output  1  two-flop-synchronized serial_in that drives the shift register serial input.
REQ-008 sr_shift_enable  output  1  single-cycle shift strobe to the shift register.
REQ-009 data_read  input  1  consumer acknowledge; one cycle high consumes rx_data.
REQ-010 rx_data  output  DATA_BITS  last good received byte.
REQ-011 data_ready  output  1  rx_data holds an unconsumed byte.
REQ-012 framing_error  output  1  last frame had a low stop bit.
REQ-013 overrun_error  output  1  a byte was overwritten before consumption.

Function
REQ-014 The block SHALL synchronize serial_in through two flops, and SHALL use a third flop for falling-edge detect; the start edge is the cycle E in which sync_serial is 0 and the previous value was 1.
REQ-015 The FSM SHALL have states IDLE, START_CHK, RECEIVE and CHECK.
REQ-016 IDLE SHALL go to START_CHK on a start edge, clearing bit_timer.
REQ-017 START_CHK SHALL, when bit_timer reaches CLKS_PER_BIT/2-1 (integer divide), go to IDLE if sync_serial is 1 (glitch rejected, no outputs change); otherwise it SHALL go to RECEIVE with bit_timer and bit_cnt cleared.
REQ-018 RECEIVE SHALL assert sr_shift_enable for exactly one cycle each time bit_timer reaches CLKS_PER_BIT-1, wrapping bit_timer to 0 and incrementing bit_cnt on that cycle.
REQ-019 Strobe k (k=1..DATA_BITS+1) SHALL therefore occur at cycle E + CLKS_PER_BIT/2 + k*CLKS_PER_BIT, which is mid-bit.
REQ-020 After strobe DATA_BITS+1, RECEIVE SHALL go to CHECK; in the CHECK cycle, sr_data[DATA_BITS] is the stop bit and sr_data[DATA_BITS-1:0] is the data.
REQ-021 CHECK SHALL last 1 cycle and then return to IDLE, with the following effects:
- Stop bit = 1: rx_data <= sr_data[DATA_BITS-1:0], data_ready <= 1, framing_error <= 0.
- Stop bit = 0: framing_error <= 1; rx_data and data_ready are unchanged.
REQ-022 On a good CHECK where data_ready=1 and data_read=0, overrun_error SHALL be set to 1 and rx_data SHALL be overwritten with the new byte.
REQ-023 On a good CHECK where data_read=1 in the same cycle, the load SHALL win: data_ready stays 1 and overrun_error is not set.
REQ-024 Outside a good CHECK, data_read=1 SHALL clear data_ready and overrun_error on the next edge.
REQ-025 A start edge in the CHECK cycle SHALL be ignored; detection SHALL resume in IDLE.
REQ-026 sr_shift_enable SHALL never assert outside RECEIVE.
REQ-027 bit_timer width SHALL be $clog2(CLKS_PER_BIT); bit_cnt width SHALL be $clog2(DATA_BITS+2); neither SHALL wrap past its terminal value.

Reset
REQ-028 While n_rst=0, the block SHALL force the following values: FSM=IDLE, bit_timer=0, bit_cnt=0, sync flops and edge flop = 1, sr_shift_enable=0, rx_data=0, data_ready=0, framing_error=0, overrun_error=0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no output update, and the first start edge after release SHALL be received normally.

Verification (CLKS_PER_BIT=10, DATA_BITS=8)
REQ-030 Byte 0xA5 with stop=1 -> 9 strobes spaced 10 cycles, first at E+15; then rx_data=0xA5, data_ready=1, framing_error=0.
REQ-031 Byte 0x3C with stop=0 -> framing_error=1, data_ready and rx_data unchanged.
REQ-032 A 3-cycle low glitch on an idle line -> return to IDLE, no sr_shift_enable pulse, outputs unchanged.
REQ-033 Two frames 0x11 then 0x22 with no data_read -> rx_data=0x22, overrun_error=1; then data_read pulse -> data_ready=0 and overrun_error=0.
REQ-034 data_read asserted in the CHECK cycle of frame 0x55 while data_ready=1 -> rx_data=0x55, data_ready=1, overrun_error=0.
REQ-035 n_rst pulsed after strobe 4, then frame 0xF0 -> all outputs at reset values, then rx_data=0xF0 with data_ready=1.

Source files
------------

// File: rtl/rx_frame_ctrl.sv
// Purpose: async serial receive controller. It synchronises the line, qualifies the start bit and strobes an external shift register mid-bit.
// Latency: strobe k lands at E + CLKS_PER_BIT/2 + k*CLKS_PER_BIT; outputs update on the edge that closes the CHECK cycle.
// Backpressure: none. An unread byte is overwritten on the next good frame, and overrun_error flags the loss.
module rx_frame_ctrl #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic [DATA_BITS:0]   sr_data,
    output logic                 sync_serial,
    output logic                 sr_shift_enable,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 framing_error,
    output logic                 overrun_error
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(DATA_BITS + 2);

    localparam logic [TW-1:0] HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(CLKS_PER_BIT - 1);
    // The strobe taken while bit_cnt holds this value is the final one, which samples the stop bit.
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_BITS);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_START_CHK = 2'd1;
    localparam logic [1:0] S_RECEIVE   = 2'd2;
    localparam logic [1:0] S_CHECK     = 2'd3;

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_prev;
    logic [1:0]           r_state;
    logic [TW-1:0]        r_bit_timer;
    logic [CW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_data_ready;
    logic                 r_framing_error;
    logic                 r_overrun_error;

    logic w_start_edge;
    logic w_strobe;
    logic w_good_check;
    logic w_bad_check;

    assign w_start_edge    = ~r_sync2 & r_prev;
    assign w_strobe        = (r_state == S_RECEIVE) && (r_bit_timer == FULL_M1);
    assign w_good_check    = (r_state == S_CHECK) &&  sr_data[DATA_BITS];
    assign w_bad_check     = (r_state == S_CHECK) && !sr_data[DATA_BITS];

    assign sync_serial     = r_sync2;
    assign sr_shift_enable = w_strobe;
    assign rx_data         = r_rx_data;
    assign data_ready      = r_data_ready;
    assign framing_error   = r_framing_error;
    assign overrun_error   = r_overrun_error;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection; idles high like the line.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= serial_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Frame sequencer: qualify the start bit at its midpoint, then time DATA_BITS+1 mid-bit strobes.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= S_IDLE;
            r_bit_timer <= '0;
            r_bit_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        r_state     <= S_START_CHK;
                        r_bit_timer <= '0;
                    end
                end
                S_START_CHK: begin
                    if (r_bit_timer == HALF_M1) begin
                        r_bit_timer <= '0;
                        r_bit_cnt   <= '0;
                        // A line that is high again at mid-start-bit was a glitch.
                        r_state     <= r_sync2 ? S_IDLE : S_RECEIVE;
                    end else begin
                        r_bit_timer <= r_bit_timer + 1'b1;
                    end
                end
                S_RECEIVE: begin
                    if (r_bit_timer == FULL_M1) begin
                        r_bit_timer <= '0;
                        r_bit_cnt   <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == LAST_IDX) begin
                            r_state <= S_CHECK;
                        end
                    end else begin
                        r_bit_timer <= r_bit_timer + 1'b1;
                    end
                end
                S_CHECK: begin
                    // A start edge seen here is dropped; detection resumes from IDLE.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Result registers: a good frame loads the byte and beats a same-cycle read; a bad stop bit only flags the error.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rx_data       <= '0;
            r_data_ready    <= 1'b0;
            r_framing_error <= 1'b0;
            r_overrun_error <= 1'b0;
        end else begin
            if (w_good_check) begin
                r_rx_data       <= sr_data[DATA_BITS-1:0];
                r_data_ready    <= 1'b1;
                r_framing_error <= 1'b0;
                if (r_data_ready && !data_read) begin
                    r_overrun_error <= 1'b1;
                end
            end else begin
                if (w_bad_check) begin
                    r_framing_error <= 1'b1;
                end
                if (data_read) begin
                    r_data_ready    <= 1'b0;
                    r_overrun_error <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Purpose: directed bench for rx_frame_ctrl, which includes a model of the downstream shift register.
// Latency: frames take 10 bit times at CLKS_PER_BIT=10, and results are sampled after the frame.
// Backpressure: data_read is pulsed only at the points the bench chooses.
module tb_rx_frame_ctrl;

    localparam int CPB = 10;
    localparam int DB  = 8;

    logic          clk;
    logic          n_rst;
    logic          serial_in;
    logic [DB:0]   sr_data;
    logic          sync_serial;
    logic          sr_shift_enable;
    logic          data_read;
    logic [DB-1:0] rx_data;
    logic          data_ready;
    logic          framing_error;
    logic          overrun_error;

    int checks;
    int passes;
    int cyc;
    int strobe_total;
    int strobe_cyc [128];

    rx_frame_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .serial_in       (serial_in),
        .sr_data         (sr_data),
        .sync_serial     (sync_serial),
        .sr_shift_enable (sr_shift_enable),
        .data_read       (data_read),
        .rx_data         (rx_data),
        .data_ready      (data_ready),
        .framing_error   (framing_error),
        .overrun_error   (overrun_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream shift register: NUM_BITS=DB+1, SHIFT_MSB=0, so new bits enter at the MSB.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) sr_data <= '1;
        else if (sr_shift_enable) sr_data <= {sync_serial, sr_data[DB:1]};
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Log the cycle index of every shift strobe, sampled away from the active edge.
    always @(negedge clk) begin
        if (sr_shift_enable === 1'b1) begin
            if (strobe_total < 128) strobe_cyc[strobe_total] = cyc;
            strobe_total = strobe_total + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one frame, one line value per cycle, starting just after an edge; optionally pulse data_read in the CHECK cycle (t=98).
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic rd_in_check, output int n0);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        n0 = cyc;
        for (int t = 0; t < 100; t++) begin
            serial_in = bits[t / 10];
            if (rd_in_check) data_read = (t == 98);
            step(1);
        end
        serial_in = 1'b1;
        data_read = 1'b0;
        step(5);
    endtask

    task automatic pulse_read();
        data_read = 1'b1;
        step(1);
        data_read = 1'b0;
        step(1);
    endtask

    initial begin
        int n0;
        int base;
        logic [3:0] part;
        checks       = 0;
        passes       = 0;
        cyc          = 0;
        strobe_total = 0;
        n_rst        = 1'b0;
        serial_in    = 1'b1;
        data_read    = 1'b0;
        step(3);
        chk("reset_rx_data", 32'(rx_data), 32'h0);
        chk("reset_flags", {29'd0, data_ready, framing_error, overrun_error}, 32'h0);
        chk("reset_sync", 32'(sync_serial), 32'h1);
        n_rst = 1'b1;
        step(5);
        chk("idle_no_strobe", 32'(strobe_total), 32'd0);

        // 0xA5 good frame: the edge is detected 2 cycles after the line drops, so the first strobe comes at n0+2+15.
        base = strobe_total;
        send_frame(8'hA5, 1'b1, 1'b0, n0);
        chk("a5_strobe_count", 32'(strobe_total - base), 32'd9);
        chk("a5_first_strobe", 32'(strobe_cyc[base]), 32'(n0 + 17));
        chk("a5_second_strobe", 32'(strobe_cyc[base + 1]), 32'(n0 + 27));
        chk("a5_last_strobe", 32'(strobe_cyc[base + 8]), 32'(n0 + 97));
        chk("a5_rx_data", 32'(rx_data), 32'hA5);
        chk("a5_flags", {29'd0, data_ready, framing_error, overrun_error}, 32'b100);

        // 0x3C with a low stop bit: framing error only.
        send_frame(8'h3C, 1'b0, 1'b0, n0);
        chk("3c_rx_data", 32'(rx_data), 32'hA5);
        chk("3c_flags", {29'd0, data_ready, framing_error, overrun_error}, 32'b110);

        // 3-cycle glitch: rejected at mid-start-bit.
        base = strobe_total;
        serial_in = 1'b0;
        step(3);
        serial_in = 1'b1;
        step(30);
        chk("glitch_no_strobe", 32'(strobe_total - base), 32'd0);
        chk("glitch_rx_data", 32'(rx_data), 32'hA5);
        chk("glitch_flags", {29'd0, data_ready, framing_error, overrun_error}, 32'b110);

        pulse_read();
        chk("read_clears_ready", {29'd0, data_ready, framing_error, overrun_error}, 32'b010);

        // Two frames without a read cause an overrun.
        send_frame(8'h11, 1'b1, 1'b0, n0);
        chk("11_rx_data", 32'(rx_data), 32'h11);
        chk("11_flags", {29'd0, data_ready, framing_error, overrun_error}, 32'b100);
        send_frame(8'h22, 1'b1, 1'b0, n0);
        chk("22_rx_data", 32'(rx_data), 32'h22);
        chk("22_overrun", {29'd0, data_ready, framing_error, overrun_error}, 32'b101);
        pulse_read();
        chk("read_clears_overrun", {29'd0, data_ready, framing_error, overrun_error}, 32'b000);
        chk("read_keeps_data", 32'(rx_data), 32'h22);

        // A read in the CHECK cycle while a byte is pending: the load wins and no overrun is flagged.
        send_frame(8'h77, 1'b1, 1'b0, n0);
        chk("77_ready", {29'd0, data_ready, framing_error, overrun_error}, 32'b100);
        send_frame(8'h55, 1'b1, 1'b1, n0);
        chk("55_rx_data", 32'(rx_data), 32'h55);
        chk("55_flags", {29'd0, data_ready, framing_error, overrun_error}, 32'b100);

        // Abort a frame with reset after strobe 4, then receive 0xF0 cleanly.
        base = strobe_total;
        part = 4'hF;
        serial_in = 1'b0;
        step(10);
        for (int j = 0; j < 4; j++) begin
            serial_in = part[j];
            step(10);
        end
        chk("partial_strobes", 32'(strobe_total - base), 32'd4);
        n_rst = 1'b0;
        serial_in = 1'b1;
        step(3);
        chk("midrst_rx_data", 32'(rx_data), 32'h0);
        chk("midrst_flags", {29'd0, data_ready, framing_error, overrun_error}, 32'b000);
        chk("midrst_sync", {30'd0, sync_serial, sr_shift_enable}, 32'b10);
        n_rst = 1'b1;
        step(20);
        chk("post_rst_no_strobe", 32'(strobe_total - base), 32'd4);
        chk("post_rst_outputs", {21'd0, rx_data, data_ready, framing_error, overrun_error}, 32'h0);
        base = strobe_total;
        send_frame(8'hF0, 1'b1, 1'b0, n0);
        chk("f0_strobe_count", 32'(strobe_total - base), 32'd9);
        chk("f0_first_strobe", 32'(strobe_cyc[base]), 32'(n0 + 17));
        chk("f0_rx_data", 32'(rx_data), 32'hF0);
        chk("f0_flags", {29'd0, data_ready, framing_error, overrun_error}, 32'b100);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
